// File: rtl/arch_rat_multi_if.sv
// rtl/arch_rat_multi_if.sv - commit, free and restore signal bundle for the architectural rename table
interface arch_rat_multi_if #(
    parameter int COMMIT_WIDTH  = 2,
    parameter int LREG_NUM      = 32,
    parameter int PREG_W        = 6,
    parameter int RESTORE_LANES = 8
);
    localparam int LREG_W = $clog2(LREG_NUM);

    logic [COMMIT_WIDTH-1:0]          commit_valid;
    logic [COMMIT_WIDTH-1:0]          commit_need_to_wb;
    logic [COMMIT_WIDTH*LREG_W-1:0]   commit_lrd;
    logic [COMMIT_WIDTH*PREG_W-1:0]   commit_prd;
    logic [COMMIT_WIDTH-1:0]          free_valid;
    logic [COMMIT_WIDTH*PREG_W-1:0]   free_prd;
    logic                             restore_req;
    logic                             restore_busy;
    logic                             restore_valid;
    logic [LREG_W-1:0]                restore_idx;
    logic [RESTORE_LANES*PREG_W-1:0]  restore_data;
    logic                             restore_last;

    modport master (
        output commit_valid, commit_need_to_wb, commit_lrd, commit_prd, restore_req,
        input  free_valid, free_prd, restore_busy, restore_valid, restore_idx,
               restore_data, restore_last
    );

    modport slave (
        input  commit_valid, commit_need_to_wb, commit_lrd, commit_prd, restore_req,
        output free_valid, free_prd, restore_busy, restore_valid, restore_idx,
               restore_data, restore_last
    );
endinterface

// File: rtl/arch_rat_multi.sv
// rtl/arch_rat_multi.sv - committed logical-to-physical rename table with multi-lane free and chunked restore
// Optional debug_rat port enabled by ARCH_RAT_DIFFTEST_EN.
module arch_rat_multi #(
    parameter int COMMIT_WIDTH  = 2,
    parameter int LREG_NUM      = 32,
    parameter int PREG_W        = 6,
    parameter int RESTORE_LANES = 8
) (
    input  logic                       clock,
    input  logic                       reset,
`ifdef ARCH_RAT_DIFFTEST_EN
    output logic [LREG_NUM*PREG_W-1:0] debug_rat,
`endif
    arch_rat_multi_if.slave            rat_if
);
    localparam int LREG_W = $clog2(LREG_NUM);

    typedef enum logic {IDLE, WALK} state_t;

    logic [PREG_W-1:0] rat_q [LREG_NUM];
    logic [LREG_W-1:0] lrd   [COMMIT_WIDTH];
    logic [PREG_W-1:0] prd   [COMMIT_WIDTH];
    logic [PREG_W-1:0] disp  [COMMIT_WIDTH];
    logic [COMMIT_WIDTH-1:0] wren;

    state_t            state_q, state_d;
    logic [LREG_W-1:0] idx_q, idx_d;
    logic              last;

    // An older lane in the same group already displaced the table entry, so a
    // younger lane hitting the same lrd frees that lane's new preg instead.
    always_comb begin
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            lrd[i]  = rat_if.commit_lrd[i*LREG_W +: LREG_W];
            prd[i]  = rat_if.commit_prd[i*PREG_W +: PREG_W];
            wren[i] = rat_if.commit_valid[i] & rat_if.commit_need_to_wb[i] & (lrd[i] != '0);
        end
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            disp[i] = rat_q[lrd[i]];
            for (int j = 0; j < i; j++) begin
                if (wren[j] && (lrd[j] == lrd[i])) disp[i] = prd[j];
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < LREG_NUM; i++) rat_q[i] <= PREG_W'(i);
            rat_if.free_valid <= '0;
            rat_if.free_prd   <= '0;
        end else begin
            // Ascending lane order lets the youngest lane win the entry.
            for (int i = 0; i < COMMIT_WIDTH; i++) begin
                if (wren[i]) begin
                    rat_q[lrd[i]]                          <= prd[i];
                    rat_if.free_prd[i*PREG_W +: PREG_W]    <= disp[i];
                end
            end
            rat_if.free_valid <= wren;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    assign last = (idx_q == LREG_W'(LREG_NUM - RESTORE_LANES));

    always_comb begin
        state_d              = state_q;
        idx_d                = idx_q;
        rat_if.restore_busy  = 1'b0;
        rat_if.restore_valid = 1'b0;
        rat_if.restore_idx   = '0;
        rat_if.restore_data  = '0;
        rat_if.restore_last  = 1'b0;
        case (state_q)
            IDLE: begin
                if (rat_if.restore_req) begin
                    state_d = WALK;
                    idx_d   = '0;
                end
            end
            WALK: begin
                rat_if.restore_busy  = 1'b1;
                rat_if.restore_valid = 1'b1;
                rat_if.restore_idx   = idx_q;
                rat_if.restore_last  = last;
                for (int k = 0; k < RESTORE_LANES; k++) begin
                    rat_if.restore_data[k*PREG_W +: PREG_W] = rat_q[idx_q + LREG_W'(k)];
                end
                if (last) state_d = IDLE;
                else      idx_d   = idx_q + LREG_W'(RESTORE_LANES);
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef ARCH_RAT_DIFFTEST_EN
    always_comb begin
        for (int i = 0; i < LREG_NUM; i++) debug_rat[i*PREG_W +: PREG_W] = rat_q[i];
    end
`endif
endmodule

// File: tb/tb_arch_rat_multi.sv
// tb/tb_arch_rat_multi.sv - self-checking bench for arch_rat_multi against a sequential-commit table model
module tb_arch_rat_multi;
    localparam int CW = 2;
    localparam int LN = 32;
    localparam int PW = 6;
    localparam int RL = 8;
    localparam int LW = 5;
    localparam int NCH = LN / RL;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clock = ~clock;

    arch_rat_multi_if #(.COMMIT_WIDTH(CW), .LREG_NUM(LN), .PREG_W(PW), .RESTORE_LANES(RL)) rif ();

`ifdef ARCH_RAT_DIFFTEST_EN
    logic [LN*PW-1:0] debug_rat;
`endif

    arch_rat_multi #(.COMMIT_WIDTH(CW), .LREG_NUM(LN), .PREG_W(PW), .RESTORE_LANES(RL)) dut (
        .clock    (clock),
        .reset    (reset),
`ifdef ARCH_RAT_DIFFTEST_EN
        .debug_rat(debug_rat),
`endif
        .rat_if   (rif.slave)
    );

    logic [PW-1:0]    m_tab [LN];
    logic [CW-1:0]    m_fv;
    logic [CW*PW-1:0] m_fp;
    int               m_chunk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Commits are applied one lane at a time, oldest first: whatever a lane
    // overwrites is what it frees.
    always @(posedge clock or posedge reset) begin : model
        int nxt;
        logic [LW-1:0] l;
        if (reset) begin
            for (int i = 0; i < LN; i++) m_tab[i] = PW'(i);
            m_fv    = '0;
            m_fp    = '0;
            m_chunk = -1;
        end else begin
            nxt = m_chunk;
            if (m_chunk >= 0) nxt = (m_chunk == NCH - 1) ? -1 : m_chunk + 1;
            else if (rif.restore_req) nxt = 0;
            for (int i = 0; i < CW; i++) begin
                l = rif.commit_lrd[i*LW +: LW];
                if (rif.commit_valid[i] && rif.commit_need_to_wb[i] && l != 0) begin
                    m_fp[i*PW +: PW] = m_tab[l];
                    m_tab[l]         = rif.commit_prd[i*PW +: PW];
                    m_fv[i]          = 1'b1;
                end else begin
                    m_fv[i] = 1'b0;
                end
            end
            m_chunk = nxt;
        end
    end

    always @(negedge clock) begin : compare
        logic [RL*PW-1:0] ed;
        ed = '0;
        if (m_chunk >= 0)
            for (int k = 0; k < RL; k++) ed[k*PW +: PW] = m_tab[m_chunk*RL + k];
        check("free_valid",    64'(rif.free_valid),    64'(m_fv));
        check("free_prd",      64'(rif.free_prd),      64'(m_fp));
        check("restore_busy",  64'(rif.restore_busy),  64'(m_chunk >= 0));
        check("restore_valid", 64'(rif.restore_valid), 64'(m_chunk >= 0));
        check("restore_idx",   64'(rif.restore_idx),   (m_chunk >= 0) ? 64'(m_chunk * RL) : 64'd0);
        check("restore_data",  64'(rif.restore_data),  64'(ed));
        check("restore_last",  64'(rif.restore_last),  64'(m_chunk == NCH - 1));
    end

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic commit(input int v, input int wb, input int l0, input int p0,
                          input int l1, input int p1);
        rif.commit_valid      = CW'(v);
        rif.commit_need_to_wb = CW'(wb);
        rif.commit_lrd        = {LW'(l1), LW'(l0)};
        rif.commit_prd        = {PW'(p1), PW'(p0)};
    endtask

    initial begin : stim
        logic [RL*PW-1:0] idn;
        int busy_cnt;
        for (int k = 0; k < RL; k++) idn[k*PW +: PW] = PW'(k);
        commit(0, 0, 0, 0, 0, 0);
        rif.restore_req = 1'b0;
        #2 reset = 1'b1;
        tick();
        tick();
        check("reset_valid", 64'(rif.restore_valid), 64'd0);
        check("reset_free",  64'(rif.free_valid),    64'd0);
        reset = 1'b0;
        tick();

        // Plain restore of the identity table.
        rif.restore_req = 1'b1;
        tick();
        rif.restore_req = 1'b0;
        check("r1_idx0",  64'(rif.restore_idx),  64'd0);
        check("r1_data0", 64'(rif.restore_data), 64'(idn));
        busy_cnt = int'(rif.restore_busy);
        for (int c = 0; c < 5; c++) begin
            tick();
            busy_cnt += int'(rif.restore_busy);
        end
        check("r1_busy_cycles", 64'(busy_cnt), 64'd4);

        commit(3, 3, 5, 40, 7, 41);
        tick();
        commit(0, 0, 0, 0, 0, 0);
        check("c1_fv", 64'(rif.free_valid), 64'b11);
        check("c1_fp", 64'(rif.free_prd),   64'({6'd7, 6'd5}));

        commit(3, 3, 3, 50, 3, 51);
        tick();
        commit(0, 0, 0, 0, 0, 0);
        check("c2_fv", 64'(rif.free_valid), 64'b11);
        check("c2_fp", 64'(rif.free_prd),   64'({6'd50, 6'd3}));

        commit(3, 1, 0, 60, 9, 20);
        tick();
        commit(0, 0, 0, 0, 0, 0);
        check("c3_fv", 64'(rif.free_valid), 64'b00);
        check("c3_fp_hold", 64'(rif.free_prd), 64'({6'd50, 6'd3}));

        // Second restore: re-request and a commit during the walk.
        rif.restore_req = 1'b1;
        tick();
        check("r2_data0", 64'(rif.restore_data),
              64'({6'd41, 6'd6, 6'd40, 6'd4, 6'd51, 6'd2, 6'd1, 6'd0}));
        commit(1, 1, 30, 33, 0, 0);
        tick();
        commit(0, 0, 0, 0, 0, 0);
        rif.restore_req = 1'b0;
        check("r2_idx1", 64'(rif.restore_idx), 64'd8);
        tick();
        tick();
        check("r2_idx3",  64'(rif.restore_idx),  64'd24);
        check("r2_last",  64'(rif.restore_last), 64'd1);
        check("r2_data3", 64'(rif.restore_data),
              64'({6'd31, 6'd33, 6'd29, 6'd28, 6'd27, 6'd26, 6'd25, 6'd24}));
        rif.restore_req = 1'b1;
        tick();
        rif.restore_req = 1'b0;
        check("r2_req_on_last_ignored", 64'(rif.restore_busy), 64'd0);
        tick();
        check("r2_still_idle", 64'(rif.restore_busy), 64'd0);

        // Reset in the middle of the second chunk.
        rif.restore_req = 1'b1;
        tick();
        rif.restore_req = 1'b0;
        tick();
        check("r3_idx1", 64'(rif.restore_idx), 64'd8);
        reset = 1'b1;
        #1;
        check("rst_mid_valid", 64'(rif.restore_valid), 64'd0);
        check("rst_mid_busy",  64'(rif.restore_busy),  64'd0);
        check("rst_mid_idx",   64'(rif.restore_idx),   64'd0);
        tick();
        reset = 1'b0;
        tick();
        tick();
        check("rst_no_chunks", 64'(rif.restore_valid), 64'd0);

        rif.restore_req = 1'b1;
        tick();
        rif.restore_req = 1'b0;
        check("r4_data0_identity", 64'(rif.restore_data), 64'(idn));
        for (int c = 0; c < 5; c++) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/arch_rat_multi.md
Name: arch_rat_multi

Overview:
- Parametrised architectural rename table: holds the committed logical-to-physical register mapping.
- Sits after the ROB commit stage.
- Accepts COMMIT_WIDTH commit lanes per cycle and reports, one cycle later, the physical registers displaced by those commits so the freelist can reclaim them.
- Streams its full contents in chunks to the speculative RAT for flush recovery.

Parameters:
- COMMIT_WIDTH, 2: number of commit lanes; lane 0 is the oldest.
- LREG_NUM, 32: number of logical registers; power of two; LREG_W = log2(LREG_NUM).
- PREG_W, 6: physical register index width.
- RESTORE_LANES, 8: table entries emitted per restore cycle; must divide LREG_NUM.

Ports:
- clock  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- commit_valid  in  COMMIT_WIDTH  per-lane commit valid.
- commit_need_to_wb  in  COMMIT_WIDTH  per-lane register writeback required.
- commit_lrd  in  COMMIT_WIDTH*LREG_W  per-lane logical destination; lane i occupies bits [i*LREG_W +: LREG_W].
- commit_prd  in  COMMIT_WIDTH*PREG_W  per-lane new physical destination.
- free_valid  out  COMMIT_WIDTH  registered; lane's displaced preg is returned to the freelist.
- free_prd  out  COMMIT_WIDTH*PREG_W  registered displaced preg per lane.
- restore_req  in  1  single-cycle pulse requesting a full-table stream-out.
- restore_busy  out  1  high while a stream-out is in progress.
- restore_valid  out  1  restore_idx/restore_data are valid this cycle.
- restore_idx  out  LREG_W  logical index of the first entry in restore_data.
- restore_data  out  RESTORE_LANES*PREG_W  entries restore_idx .. restore_idx+RESTORE_LANES-1; entry k occupies [k*PREG_W +: PREG_W].
- restore_last  out  1  marks the final chunk.

Behaviour:
- Reset, asynchronous, takes effect immediately:
  - table[i] = i, zero-extended or truncated to PREG_W.
  - FSM = IDLE.
  - free_valid, free_prd, restore_busy, restore_valid, restore_idx, restore_data and restore_last all 0.
  - A reset mid-stream aborts the stream with no further chunks.
- Lane write enable: wren[i] = commit_valid[i] & commit_need_to_wb[i] & (commit_lrd[i] != 0).
  - Logical register 0 is never written; table[0] stays 0.
- Table update at the clock edge: for each entry, the youngest (highest-index) enabled lane targeting it wins.
- Displaced preg for an enabled lane i:
  - The commit_prd of the youngest lane j<i with wren[j] and the same lrd, if one exists.
  - Otherwise the pre-edge table[lrd].
  - Therefore every overwritten mapping is freed exactly once, including intra-group overwrites.
- Free output timing: free_valid[i] <= wren[i]; free_prd[i] <= displaced preg. Latency is 1 cycle.
  - When wren[i] = 0, free_prd[i] holds its previous value.
- Restore FSM has two states, IDLE and WALK.
  - In IDLE, restore_req = 1: go to WALK and set idx = 0.
  - In WALK, each cycle: restore_valid = 1, restore_idx = idx, and restore_data = current table[idx .. idx+RESTORE_LANES-1] (combinational read of registered state).
  - restore_last = (idx == LREG_NUM - RESTORE_LANES); on restore_last, return to IDLE; otherwise idx += RESTORE_LANES.
  - restore_busy = (state == WALK).
  - Timing: a request at cycle T gives chunks at T+1 .. T+N, where N = LREG_NUM/RESTORE_LANES, and IDLE at T+N+1.
  - restore_req while in WALK is ignored. A request in the same cycle the FSM returns to IDLE is also ignored, because the FSM samples the request only while in IDLE.
- Commits during WALK are still applied to the table and still produce free outputs. Chunks already emitted are not re-sent. The ROB stalls commit during restore, so this case is legal but not coherent.
- The restore outputs (restore_valid, restore_idx, restore_data, restore_last) are driven combinationally from the FSM and table; they are 0 in IDLE.

Optional Feature:
- Macro ARCH_RAT_DIFFTEST_EN.
- Defined: adds output debug_rat, width LREG_NUM*PREG_W, carrying table[i] at [i*PREG_W +: PREG_W], for difftest comparison against the reference model.
- Not defined: the port is absent and no extra logic is generated.
- Table functionality is identical either way.

Test Plan:
- Reset, then restore_req: 4 chunks (defaults) with idx 0/8/16/24; data = identity mapping; restore_last on the 4th; busy high exactly 4 cycles.
- Lane0 lrd=5 prd=40, lane1 lrd=7 prd=41 -> next cycle free_valid=11, free_prd={7,5}; the table shows table[5]=40, table[7]=41.
- Both lanes lrd=3, prd 50 (lane0) / 51 (lane1), table[3]=3 -> table[3]=51; free_prd lane0=3, lane1=50; both free_valid.
- Lane0 lrd=0 prd=60 valid+wb, lane1 need_to_wb=0 -> table unchanged, free_valid=00, table[0] remains 0.
- restore_req pulsed again during WALK, plus a commit lrd=30 prd=33 in the first WALK cycle -> only one 4-chunk stream; chunk idx 24 shows table[30]=33.
- Assert reset during the 2nd chunk -> restore_valid/busy drop to 0 immediately, table returns to identity, no further chunks.
